// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_receiver.
// Each rising edge of the receiver's data-ready level offers one byte.
// Good bytes are queued and read out through a first-word-fall-through CPU port.
// Frame errors and overflows are held in sticky flags until the CPU clears them.
module uart_rx_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_data_ready_level,
    input  logic [DATA_WIDTH-1:0]        rx_data_in,
    input  logic                         rx_frame_error_in,
    input  logic                         cpu_rd_strobe,
    input  logic                         cpu_clear_errors,
    output logic [DATA_WIDTH-1:0]        cpu_data_out,
    output logic [3:0]                   cpu_status,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         rx_irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  prev_ready;
    logic                  overflow_flag;
    logic                  frame_error_flag;

    logic push_evt;
    logic full;
    logic empty;
    logic pop_acc;
    logic push_acc;
    logic ovf_evt;
    logic ferr_evt;

    // Event decode; status is derived from registered count only.
    always_comb begin
        push_evt = rx_data_ready_level & ~prev_ready;
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        pop_acc  = cpu_rd_strobe & ~empty;
        ferr_evt = push_evt & rx_frame_error_in;
        // A full FIFO still takes the byte when a pop frees a slot this cycle.
        push_acc = push_evt & ~rx_frame_error_in & (~full | pop_acc);
        ovf_evt  = push_evt & ~rx_frame_error_in & full & ~pop_acc;
    end

    // Pointers, count, edge detector and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            // Starts high so a level already high out of reset is not a new byte.
            prev_ready       <= 1'b1;
            overflow_flag    <= 1'b0;
            frame_error_flag <= 1'b0;
        end else begin
            prev_ready <= rx_data_ready_level;
            if (push_acc) wr_ptr <= wr_ptr + PW'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set wins over a clear in the same cycle.
            if (ovf_evt)               overflow_flag <= 1'b1;
            else if (cpu_clear_errors) overflow_flag <= 1'b0;
            if (ferr_evt)              frame_error_flag <= 1'b1;
            else if (cpu_clear_errors) frame_error_flag <= 1'b0;
        end
    end

    // Byte storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= rx_data_in;
    end

    // FWFT read port and status outputs.
    always_comb begin
        cpu_data_out = empty ? '0 : mem[rd_ptr];
        cpu_status   = {frame_error_flag, overflow_flag, full, ~empty};
        fifo_count   = count;
        rx_irq       = ~empty;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_data_ready_level;
    logic [7:0] rx_data_in;
    logic       rx_frame_error_in;
    logic       cpu_rd_strobe;
    logic       cpu_clear_errors;
    logic [7:0] cpu_data_out;
    logic [3:0] cpu_status;
    logic [3:0] fifo_count;
    logic       rx_irq;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(.DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .rx_data_ready_level (rx_data_ready_level),
        .rx_data_in          (rx_data_in),
        .rx_frame_error_in   (rx_frame_error_in),
        .cpu_rd_strobe       (cpu_rd_strobe),
        .cpu_clear_errors    (cpu_clear_errors),
        .cpu_data_out        (cpu_data_out),
        .cpu_status          (cpu_status),
        .fifo_count          (fifo_count),
        .rx_irq              (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic fe);
        rx_data_in          = d;
        rx_frame_error_in   = fe;
        rx_data_ready_level = 1'b1;
        tick();
        rx_data_ready_level = 1'b0;
        rx_frame_error_in   = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check(tag, cpu_data_out, d);
        cpu_rd_strobe = 1'b1;
        tick();
        cpu_rd_strobe = 1'b0;
    endtask

    task automatic clear_errors();
        cpu_clear_errors = 1'b1;
        tick();
        cpu_clear_errors = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        rx_data_ready_level = 1'b0;
        rx_data_in          = '0;
        rx_frame_error_in   = 1'b0;
        cpu_rd_strobe       = 1'b0;
        cpu_clear_errors    = 1'b0;
        repeat (10) tick();
        check("reset_count",  fifo_count,   4'd0);
        check("reset_status", cpu_status,   4'b0000);
        check("reset_data",   cpu_data_out, 8'h00);
        check("reset_irq",    rx_irq,       1'b0);
        reset = 1'b0;
        tick();

        // Basic path: level high 3 cycles gives one push.
        rx_data_in          = 8'hB2;
        rx_data_ready_level = 1'b1;
        tick();
        check("basic_latency_irq", rx_irq, 1'b1);
        tick();
        tick();
        rx_data_ready_level = 1'b0;
        tick();
        check("basic_count",  fifo_count,   4'd1);
        check("basic_status", cpu_status,   4'b0001);
        check("basic_data",   cpu_data_out, 8'hB2);
        check("basic_irq",    rx_irq,       1'b1);
        cpu_rd_strobe = 1'b1;
        tick();
        cpu_rd_strobe = 1'b0;
        check("basic_pop_count", fifo_count,   4'd0);
        check("basic_pop_data",  cpu_data_out, 8'h00);
        check("basic_pop_irq",   rx_irq,       1'b0);

        // Pop while empty is ignored.
        cpu_rd_strobe = 1'b1;
        tick();
        cpu_rd_strobe = 1'b0;
        check("empty_pop_status", cpu_status, 4'b0000);
        check("empty_pop_count",  fifo_count, 4'd0);

        // Frame error.
        push_byte(8'hB2, 1'b1);
        check("ferr_count",  fifo_count, 4'd0);
        check("ferr_status", cpu_status, 4'b1000);
        clear_errors();
        check("ferr_clear", cpu_status, 4'b0000);

        // Fill, overflow, drain.
        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0);
        check("fill_count",  fifo_count, 4'd8);
        check("fill_status", cpu_status, 4'b0011);
        push_byte(8'h09, 1'b0);
        check("ovf_count",  fifo_count, 4'd8);
        check("ovf_status", cpu_status, 4'b0111);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("drain_%0d", i), 8'(i));
        check("drain_count",  fifo_count, 4'd0);
        check("drain_status", cpu_status, 4'b0100);
        clear_errors();
        check("drain_clear", cpu_status, 4'b0000);

        // Wrap: push 5, pop 5, then fill with A0..A7 across the pointer wrap.
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) pop_expect($sformatf("pre_wrap_%0d", i), 8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i), 1'b0);
        check("wrap_full", cpu_status, 4'b0011);

        // Full with same-cycle push and pop: A0 leaves, A8 enters, no overflow.
        rx_data_in          = 8'hA8;
        rx_data_ready_level = 1'b1;
        cpu_rd_strobe       = 1'b1;
        tick();
        rx_data_ready_level = 1'b0;
        cpu_rd_strobe       = 1'b0;
        tick();
        check("full_pushpop_count",  fifo_count, 4'd8);
        check("full_pushpop_status", cpu_status, 4'b0011);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("wrap_rd_%0d", i), 8'hA0 + 8'(i));
        check("wrap_empty", fifo_count, 4'd0);

        // Empty with same-cycle push and pop: pop ignored, push kept.
        rx_data_in          = 8'hC3;
        rx_data_ready_level = 1'b1;
        cpu_rd_strobe       = 1'b1;
        tick();
        rx_data_ready_level = 1'b0;
        cpu_rd_strobe       = 1'b0;
        check("empty_pushpop_count", fifo_count,   4'd1);
        check("empty_pushpop_data",  cpu_data_out, 8'hC3);
        tick();
        pop_expect("empty_pushpop_pop", 8'hC3);

        // Level held high for 50 cycles gives exactly one entry.
        rx_data_in          = 8'h5A;
        rx_data_ready_level = 1'b1;
        repeat (50) tick();
        rx_data_ready_level = 1'b0;
        tick();
        check("hold_count", fifo_count,   4'd1);
        check("hold_data",  cpu_data_out, 8'h5A);

        // Build 3 entries with overflow set, then reset with a pending pop.
        for (int i = 0; i < 7; i++) push_byte(8'h60 + 8'(i), 1'b0);
        push_byte(8'h6F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cpu_rd_strobe = 1'b1;
            tick();
        end
        cpu_rd_strobe = 1'b0;
        check("pre_reset_count",  fifo_count, 4'd3);
        check("pre_reset_status", cpu_status, 4'b0101);
        reset               = 1'b1;
        rx_data_ready_level = 1'b1;
        cpu_rd_strobe       = 1'b1;
        tick();
        check("mid_reset_count",  fifo_count,   4'd0);
        check("mid_reset_status", cpu_status,   4'b0000);
        check("mid_reset_data",   cpu_data_out, 8'h00);
        reset         = 1'b0;
        cpu_rd_strobe = 1'b0;
        repeat (4) tick();
        check("post_reset_level_high", fifo_count, 4'd0);
        rx_data_ready_level = 1'b0;
        tick();

        // Clear in the same cycle as a frame-error push: set wins.
        rx_data_in          = 8'h77;
        rx_frame_error_in   = 1'b1;
        rx_data_ready_level = 1'b1;
        cpu_clear_errors    = 1'b1;
        tick();
        rx_data_ready_level = 1'b0;
        rx_frame_error_in   = 1'b0;
        cpu_clear_errors    = 1'b0;
        check("clear_collision", cpu_status, 4'b1000);
        clear_errors();
        check("clear_after", cpu_status, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
